// File: rtl/flght_pkg.sv
// Shared types and helpers for the flight sequencer.
package flght_pkg;

    localparam int THRST_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        FLY  = 2'd2,
        LAND = 2'd3
    } flght_state_t;

    // One ramp step toward the target; never overshoots.
    function automatic logic [THRST_W-1:0] ramp_step(
        input logic [THRST_W-1:0] cur,
        input logic [THRST_W-1:0] tgt
    );
        if (cur < tgt) return cur + THRST_W'(1);
        if (cur > tgt) return cur - THRST_W'(1);
        return cur;
    endfunction

endpackage

// File: rtl/flght_seq_if.sv
// Command/status bundle between the command processor, flight controller and sequencer.
interface flght_seq_if;
    logic                         cmd_cal;
    logic                         cal_done;
    logic                         cmd_rdy;
    logic                         disarm;
    logic [flght_pkg::THRST_W-1:0] thrst_cmd;
    logic                         strt_cal;
    logic                         inertial_cal;
    logic                         mtrs_off;
    logic [flght_pkg::THRST_W-1:0] thrst;
    logic                         failsafe;

    modport master (
        output cmd_cal, cal_done, cmd_rdy, disarm, thrst_cmd,
        input  strt_cal, inertial_cal, mtrs_off, thrst, failsafe
    );

    modport slave (
        input  cmd_cal, cal_done, cmd_rdy, disarm, thrst_cmd,
        output strt_cal, inertial_cal, mtrs_off, thrst, failsafe
    );
endinterface

// File: rtl/flght_seq_tick_gen.sv
// Divide-by-DIV counter with synchronous clear; tick is high while the count sits at DIV-1.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/flght_seq.sv
// Flight sequencer: calibrate/arm, soft thrust ramp, disarm, and heartbeat-loss descent.
//   state | meaning
//   IDLE  | motors forced off, thrust 0
//   CAL   | inertial calibration running, thrust 0
//   FLY   | thrust ramps toward thrst_cmd, heartbeat watched
//   LAND  | heartbeat lost, thrust ramps down to 0
module flght_seq
    import flght_pkg::*;
#(
    parameter logic [15:0] RAMP_DIV = 16'd50000,
    parameter logic [25:0] COMM_TMO = 26'd50_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    flght_seq_if.slave   bus
);
    localparam int TW = $clog2(COMM_TMO);
    localparam logic [TW-1:0] TMO_LAST = TW'(COMM_TMO - 26'd1);

    flght_state_t        state_q, state_d;
    logic [THRST_W-1:0]  thrst_q, thrst_d;
    logic [TW-1:0]       comm_q;
    logic                tick;
    logic                expired;
    logic                strt_cal_q, inertial_cal_q, mtrs_off_q, failsafe_q;

    assign expired = (comm_q == TMO_LAST);

    // Ramp phase restarts on every state change so each state sees a full first step.
    tick_gen #(.DIV({16'd0, RAMP_DIV})) u_ramp_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_d != state_q),
        .en    ((state_q == FLY) || (state_q == LAND)),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        thrst_d = thrst_q;
        case (state_q)
            IDLE: begin
                thrst_d = '0;
                if (!bus.disarm && bus.cmd_cal) state_d = CAL;
            end
            CAL: begin
                thrst_d = '0;
                if (bus.disarm)        state_d = IDLE;
                else if (bus.cal_done) state_d = FLY;
            end
            FLY: begin
                if (bus.disarm) begin
                    state_d = IDLE;
                    thrst_d = '0;
                end else begin
                    if (tick) thrst_d = ramp_step(thrst_q, bus.thrst_cmd);
                    if (expired && !bus.cmd_rdy) state_d = LAND;
                end
            end
            LAND: begin
                if (bus.disarm) begin
                    state_d = IDLE;
                    thrst_d = '0;
                end else if (bus.cmd_rdy) begin
                    state_d = FLY;
                end else if (tick) begin
                    if (thrst_q == '0) state_d = IDLE;
                    else               thrst_d = thrst_q - THRST_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                thrst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            thrst_q <= '0;
        end else begin
            state_q <= state_d;
            thrst_q <= thrst_d;
        end
    end

    // Heartbeat timer only runs while staying in FLY; it parks at the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comm_q <= '0;
        end else if ((state_q != FLY) || (state_d != FLY) || bus.cmd_rdy) begin
            comm_q <= '0;
        end else if (!expired) begin
            comm_q <= comm_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
            mtrs_off_q     <= 1'b1;
            failsafe_q     <= 1'b0;
        end else begin
            strt_cal_q     <= (state_q == IDLE) && (state_d == CAL);
            inertial_cal_q <= (state_d == CAL);
            mtrs_off_q     <= (state_d == IDLE);
            failsafe_q     <= (state_d == LAND);
        end
    end

    assign bus.strt_cal     = strt_cal_q;
    assign bus.inertial_cal = inertial_cal_q;
    assign bus.mtrs_off     = mtrs_off_q;
    assign bus.failsafe     = failsafe_q;
    assign bus.thrst        = thrst_q;
endmodule

// File: tb/tb_flght_seq.sv
// Bench for flght_seq: cycle-level reference model plus directed scenarios with literal expectations.
module tb_flght_seq;
    localparam int RD = 4;
    localparam int CT = 64;
    localparam int M_IDLE = 0, M_CAL = 1, M_FLY = 2, M_LAND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    flght_seq_if bus();

    flght_seq #(.RAMP_DIV(16'd4), .COMM_TMO(26'd64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode, thrust, cycles spent in the current mode, cycles since heartbeat.
    int m_mode, m_thr, m_phase, m_hb;
    bit m_strt;

    always @(posedge clk or negedge rst_n) begin : model
        int  nm, nt;
        bit  tick, ns;
        if (!rst_n) begin
            m_mode  <= M_IDLE;
            m_thr   <= 0;
            m_phase <= 0;
            m_hb    <= 0;
            m_strt  <= 1'b0;
        end else begin
            tick = (m_mode == M_FLY || m_mode == M_LAND) && (m_phase % RD == RD - 1);
            nm = m_mode;
            nt = m_thr;
            ns = 1'b0;
            if (m_mode == M_IDLE) begin
                if (bus.cmd_cal && !bus.disarm) begin
                    nm = M_CAL;
                    ns = 1'b1;
                end
            end else if (m_mode == M_CAL) begin
                if (bus.disarm)        nm = M_IDLE;
                else if (bus.cal_done) nm = M_FLY;
            end else if (m_mode == M_FLY) begin
                if (bus.disarm) begin
                    nm = M_IDLE;
                    nt = 0;
                end else begin
                    if (tick && m_thr < int'(bus.thrst_cmd)) nt = m_thr + 1;
                    if (tick && m_thr > int'(bus.thrst_cmd)) nt = m_thr - 1;
                    if (m_hb >= CT - 1 && !bus.cmd_rdy) nm = M_LAND;
                end
            end else begin
                if (bus.disarm) begin
                    nm = M_IDLE;
                    nt = 0;
                end else if (bus.cmd_rdy) begin
                    nm = M_FLY;
                end else if (tick) begin
                    if (m_thr == 0) nm = M_IDLE;
                    else            nt = m_thr - 1;
                end
            end
            m_hb    <= (m_mode == M_FLY && nm == M_FLY && !bus.cmd_rdy) ? m_hb + 1 : 0;
            m_phase <= (nm == m_mode) ? m_phase + 1 : 0;
            m_mode  <= nm;
            m_thr   <= nt;
            m_strt  <= ns;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_thrst",        int'(bus.thrst),        m_thr);
            chk("m_mtrs_off",     int'(bus.mtrs_off),     int'(m_mode == M_IDLE));
            chk("m_inertial_cal", int'(bus.inertial_cal), int'(m_mode == M_CAL));
            chk("m_failsafe",     int'(bus.failsafe),     int'(m_mode == M_LAND));
            chk("m_strt_cal",     int'(bus.strt_cal),     int'(m_strt));
        end
    end

    task automatic pulse(input bit c, input bit d, input bit r, input bit x);
        bus.cmd_cal  = c;
        bus.cal_done = d;
        bus.cmd_rdy  = r;
        bus.disarm   = x;
        @(negedge clk);
        bus.cmd_cal  = 1'b0;
        bus.cal_done = 1'b0;
        bus.cmd_rdy  = 1'b0;
        bus.disarm   = 1'b0;
    endtask

    task automatic run(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            bus.cmd_rdy = (per != 0) && (i % per == per - 1);
            @(negedge clk);
        end
        bus.cmd_rdy = 1'b0;
    endtask

    initial begin
        bus.cmd_cal   = 1'b0;
        bus.cal_done  = 1'b0;
        bus.cmd_rdy   = 1'b0;
        bus.disarm    = 1'b0;
        bus.thrst_cmd = 9'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mtrs_off", int'(bus.mtrs_off), 1);
        chk("rst_thrst",    int'(bus.thrst), 0);
        chk("rst_failsafe", int'(bus.failsafe), 0);

        // Arm: calibration handshake
        bus.thrst_cmd = 9'd10;
        pulse(1, 0, 0, 0);
        chk("cal_strt",     int'(bus.strt_cal), 1);
        chk("cal_inertial", int'(bus.inertial_cal), 1);
        chk("cal_mtrs_on",  int'(bus.mtrs_off), 0);
        run(1, 0);
        chk("strt_once", int'(bus.strt_cal), 0);
        pulse(1, 0, 0, 0);
        chk("no_repulse", int'(bus.strt_cal), 0);
        pulse(0, 1, 0, 0);
        chk("fly_inertial", int'(bus.inertial_cal), 0);
        chk("fly_thrst0",   int'(bus.thrst), 0);

        // Ramp up to 10, then down to 7
        run(20, 20);
        chk("ramp_half", int'(bus.thrst), 5);
        run(20, 20);
        chk("ramp_top", int'(bus.thrst), 10);
        bus.thrst_cmd = 9'd7;
        run(16, 0);
        chk("ramp_down", int'(bus.thrst), 7);
        run(8, 0);
        chk("ramp_hold", int'(bus.thrst), 7);
        bus.thrst_cmd = 9'd10;
        run(20, 10);
        chk("ramp_back", int'(bus.thrst), 10);

        // Heartbeat loss: descent to IDLE
        run(63, 0);
        chk("tmo_not_yet", int'(bus.failsafe), 0);
        run(1, 0);
        chk("tmo_land", int'(bus.failsafe), 1);
        chk("land_thrst", int'(bus.thrst), 10);
        run(40, 0);
        chk("land_zero", int'(bus.thrst), 0);
        run(3, 0);
        chk("land_still", int'(bus.failsafe), 1);
        run(1, 0);
        chk("land_idle", int'(bus.mtrs_off), 1);
        chk("land_fs_off", int'(bus.failsafe), 0);

        // Disarm in CAL, disarm together with cal_done, cmd_cal in FLY, disarm in FLY
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        chk("dis_cal", int'(bus.mtrs_off), 1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 1);
        chk("dis_done_idle", int'(bus.mtrs_off), 1);
        chk("dis_done_inert", int'(bus.inertial_cal), 0);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        run(40, 20);
        chk("fly2_top", int'(bus.thrst), 10);
        pulse(1, 0, 0, 0);
        chk("cal_in_fly", int'(bus.strt_cal), 0);
        chk("cal_in_fly_inert", int'(bus.inertial_cal), 0);
        pulse(0, 0, 0, 1);
        chk("dis_fly_thrst", int'(bus.thrst), 0);
        chk("dis_fly_off", int'(bus.mtrs_off), 1);

        // LAND recovery at 6 and heartbeat on the expiry cycle
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        run(40, 20);
        run(64, 0);
        chk("land2", int'(bus.failsafe), 1);
        run(17, 0);
        chk("land2_six", int'(bus.thrst), 6);
        bus.thrst_cmd = 9'd8;
        pulse(0, 0, 1, 0);
        chk("recover_fs", int'(bus.failsafe), 0);
        chk("no_jump", int'(bus.thrst), 6);
        run(8, 0);
        chk("recover_ramp", int'(bus.thrst), 8);
        run(55, 0);
        pulse(0, 0, 1, 0);
        chk("rdy_at_expiry", int'(bus.failsafe), 0);
        run(63, 0);
        chk("tmo2_not_yet", int'(bus.failsafe), 0);
        run(1, 0);
        chk("tmo2_land", int'(bus.failsafe), 1);
        pulse(0, 0, 0, 1);
        chk("dis_land_thrst", int'(bus.thrst), 0);
        chk("dis_land_off", int'(bus.mtrs_off), 1);
        chk("dis_land_fs", int'(bus.failsafe), 0);

        // Asynchronous reset mid-ramp, then cal_done in IDLE
        bus.thrst_cmd = 9'd10;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        run(20, 20);
        chk("pre_rst_thrst", int'(bus.thrst), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_thrst", int'(bus.thrst), 0);
        chk("arst_mtrs_off", int'(bus.mtrs_off), 1);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(0, 1, 0, 0);
        chk("done_in_idle", int'(bus.mtrs_off), 1);
        chk("done_in_idle_inert", int'(bus.inertial_cal), 0);
        run(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flght_seq.md
Name: flght_seq

Overview:
- Top-level flight sequencer between the command processor and the flight controller / inertial interface.
- Arms the airframe via inertial calibration, then soft-ramps thrust toward the commanded level.
- Forces motors off on disarm.
- Performs a failsafe controlled descent when the command heartbeat is lost.

Parameters:
RAMP_DIV, 16'd50000, clocks per thrust ramp step (1 LSB per step, up or down); legal range >= 2
COMM_TMO, 26'd50_000_000, clocks in FLY without cmd_rdy before entering LAND (1 s @ 50 MHz); legal range >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  reset
cmd_cal  in  1  1-cycle pulse: request calibration/arm
cal_done  in  1  1-cycle pulse from inertial interface: calibration finished
cmd_rdy  in  1  1-cycle pulse: any valid command received (heartbeat)
disarm  in  1  1-cycle pulse: emergency motors-off
thrst_cmd  in  9  commanded thrust, unsigned
strt_cal  out  1  1-cycle pulse to inertial interface: begin calibration
inertial_cal  out  1  high throughout CAL; flight controller runs CAL_SPEED
mtrs_off  out  1  high in IDLE; ESC outputs forced to 0
thrst  out  9  ramped thrust to flight controller, unsigned
failsafe  out  1  high in LAND

Behaviour:
- Reset and clocking: rst_n is asynchronous, active-low; clk is the clock. All outputs are registered.
- Reset values: state=IDLE, mtrs_off=1, thrst=0, strt_cal=0, inertial_cal=0, failsafe=0, both counters=0. Assertion mid-operation returns to these values immediately, with no ramp-down.
- States: IDLE, CAL, FLY, LAND. Priority within any state: disarm > all other inputs.
- IDLE: mtrs_off=1, thrst held 0.
  - cmd_cal -> CAL. strt_cal=1 for exactly the first CAL cycle (1 cycle after cmd_cal).
  - Other inputs ignored.
- CAL: inertial_cal=1, mtrs_off=0, thrst=0.
  - cal_done -> FLY.
  - disarm -> IDLE.
  - cmd_cal ignored, with no re-pulse of strt_cal.
  - cal_done and disarm in the same cycle -> IDLE.
  - No internal timeout.
- FLY: mtrs_off=0.
  - Ramp tick counter counts 0..RAMP_DIV-1 and pulses tick at RAMP_DIV-1. It clears on every state entry.
  - On tick: thrst<thrst_cmd -> +1; thrst>thrst_cmd -> -1; equal -> hold.
  - thrst never steps past thrst_cmd. A thrst_cmd change mid-ramp retargets on the next tick.
- Comm timer (FLY only):
  - Clears on cmd_rdy and on FLY entry; otherwise increments.
  - Reaching COMM_TMO-1 without cmd_rdy -> LAND on the next edge.
  - cmd_rdy in the same cycle as expiry wins: stay FLY, timer=0.
- LAND: failsafe=1, mtrs_off=0.
  - On each tick, thrst decrements by 1; thrst_cmd is ignored.
  - thrst==0 on a tick boundary -> IDLE.
  - cmd_rdy -> FLY, with no thrst jump; the ramp resumes from the current value toward thrst_cmd.
  - disarm -> IDLE.
- disarm in FLY or LAND: next cycle state=IDLE, thrst=0, mtrs_off=1.
- Counter widths are sized from the parameters. Counters must not wrap: the tick counter wraps only by design at RAMP_DIV-1; the comm timer saturates.
- Latency: any input event is reflected on outputs 1 clk later.

Decomposition:
- Shared package (flght_pkg): state enum typedef {IDLE, CAL, FLY, LAND}; THRST_W=9.
- One natural sub-module, tick_gen: parameterised divide counter with sync clear and a 1-cycle tick out. Instantiated once for the ramp.
- The comm timer stays inline: its clear/saturate logic differs from tick_gen.

Test Plan (sim with RAMP_DIV=4, COMM_TMO=64):
- Reset, then cmd_cal pulse -> strt_cal=1 for exactly 1 cycle, inertial_cal=1, mtrs_off=0; cal_done -> inertial_cal=0 on next edge, state FLY.
- FLY, thrst_cmd=9'd10, cmd_rdy every 20 clks -> thrst rises 0→10, one step per 4 clks (40 clks); then thrst_cmd=9'd7 -> falls to 7 and holds.
- FLY at thrst=10, withhold cmd_rdy -> failsafe=1 after 64 clks; thrst decrements 1 per 4 clks to 0; then mtrs_off=1, failsafe=0.
- LAND at thrst=6, cmd_rdy pulse -> failsafe=0, thrst ramps 6→thrst_cmd with no jump; cmd_rdy coincident with timer expiry -> stays FLY.
- disarm during CAL, FLY (thrst=10) and LAND -> next cycle thrst=0, mtrs_off=1; disarm+cal_done same cycle -> IDLE.
- rst_n asserted mid-ramp (thrst=5) -> outputs at reset values asynchronously; cmd_cal in FLY and cal_done in IDLE -> no state change.
